pix_wr_buf: RTL

Pixel write buffer between the pixel generator and the shared frame-buffer SRAM port. Every cycle the generator can present one pixel write: an 8-bit X, an 8-bit Y and 3-bit R/G/B. This block absorbs those writes in a first-word-fall-through FIFO and replays them to the memory arbiter through a req/ack handshake. Writes that arrive while the FIFO is full are dropped, and the drops are counted.

---
 rtl/pix_wr_buf.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pix_wr_buf.sv
// ============================================================================
// Module   : pix_wr_buf
// Purpose  : Pixel write buffer. Absorbs one pixel write per cycle from the
//            pixel generator into a first-word-fall-through FIFO and replays
//            the entries to the frame-buffer memory arbiter over a req/ack
//            handshake. Writes arriving while the FIFO is full are dropped
//            and counted.
// Revision : 1.0 - initial release
//
// Parameters
//   DEPTH_LOG2 : FIFO holds 2**DEPTH_LOG2 entries (1..8)
//
// Ports
//   CLK      in   1  clock, rising edge
//   NRST     in   1  asynchronous active-low reset
//   X, Y     in   8  pixel column / row
//   R, G, B  in   3  pixel colour
//   WE       in   1  pixel valid
//   FULL     out  1  FIFO holds 2**DEPTH_LOG2 entries
//   MEM_REQ  out  1  head entry valid (FIFO not empty)
//   MEM_ADDR out 16  {Y,X} of head entry, 0 when empty
//   MEM_DATA out  9  {R,G,B} of head entry, 0 when empty
//   MEM_ACK  in   1  arbiter accepts head entry
//   DROP_CNT out 16  saturating count of dropped writes
//
// Configuration macro
//   PIXWR_DROPCNT_EN : defined   -> 16-bit saturating drop counter built
//                      undefined -> DROP_CNT tied to zero
// ============================================================================
`default_nettype none

module pix_wr_buf #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [7:0]  X,
  input  logic [7:0]  Y,
  input  logic [2:0]  R,
  input  logic [2:0]  G,
  input  logic [2:0]  B,
  input  logic        WE,
  output logic        FULL,
  output logic        MEM_REQ,
  output logic [15:0] MEM_ADDR,
  output logic [8:0]  MEM_DATA,
  input  logic        MEM_ACK,
  output logic [15:0] DROP_CNT
);

  localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_COUNT_MAX = (DEPTH_LOG2+1)'(c_DEPTH);

  // Entry layout: {Y[24:17], X[16:9], R[8:6], G[5:3], B[2:0]}
  logic [24:0]           r_mem [0:c_DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic        w_full;
  logic        w_req;
  logic        w_push;
  logic        w_pop;
  logic [24:0] w_head;

  // FULL/REQ come only from the registered count; a pop in the same cycle
  // never frees a slot for the incoming write.
  assign w_full = (r_count == c_COUNT_MAX);
  assign w_req  = (r_count != '0);
  assign w_push = WE & ~w_full;
  assign w_pop  = w_req & MEM_ACK;

  // Storage array is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= {Y, X, R, G, B};
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + DEPTH_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head   = r_mem[r_rptr];
  assign FULL     = w_full;
  assign MEM_REQ  = w_req;
  assign MEM_ADDR = w_req ? w_head[24:9] : 16'h0000;
  assign MEM_DATA = w_req ? w_head[8:0]  : 9'h000;

`ifdef PIXWR_DROPCNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  assign w_drop = WE & w_full;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_drop_cnt <= 16'h0000;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'h0001;
    end
  end

  assign DROP_CNT = r_drop_cnt;
`else
  assign DROP_CNT = 16'h0000;
`endif

endmodule

`default_nettype wire
